// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer: op encodings, FSM states and
// divider depth.
package muldiv_pkg;

  localparam int unsigned DIV_ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [31:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem_i, dvd_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~diff[32];
  assign rem_o   = q_bit_o ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: single-cycle multiply, 32-step restoring divide.
// Define MULDIV_DIV0_FAST_EN to finish divide-by-zero in one cycle.
module muldiv_ctrl #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic        annul_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(DIV_ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITERS - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quot_q, quot_d;   // dividend bits shift out as quotient bits shift in
  logic [31:0]     dvsr_q, dvsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic        is_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] step_rem, q_fin;
  logic        step_q;
  logic        div0_fast;

  div_step u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quot_q[31]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // MULT and DIV share the signed flag in op bit 0 being clear.
  assign is_signed = ~req_op_i[0];
  assign ext_a     = {{32{is_signed & req_a_i[31]}}, req_a_i};
  assign ext_b     = {{32{is_signed & req_b_i[31]}}, req_b_i};
  assign prod      = ext_a * ext_b;
  assign q_fin     = {quot_q[30:0], step_q};

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = (req_b_i == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (!req_op_i[1]) begin
            {hi_d, lo_d} = prod;
            state_d      = StDone;
          end else if (div0_fast) begin
            hi_d    = req_a_i;
            lo_d    = (is_signed && req_a_i[31]) ? 32'd1 : 32'hFFFF_FFFF;
            state_d = StDone;
          end else begin
            quot_d  = mag32(req_a_i, is_signed);
            dvsr_d  = mag32(req_b_i, is_signed);
            rem_d   = '0;
            qneg_d  = is_signed & (req_a_i[31] ^ req_b_i[31]);
            rneg_d  = is_signed & req_a_i[31];
            cnt_d   = '0;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d  = step_rem;
        quot_d = q_fin;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          lo_d    = qneg_q ? -q_fin : q_fin;
          hi_d    = rneg_q ? -step_rem : step_rem;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (annul_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign done_o     = (state_q == StDone);
  assign busy_o     = (state_q != StIdle);
  assign stallreq_o = req_valid_i & ~done_o;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table through a scoreboard plus annul/reset sequences.
module tb_muldiv_ctrl;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;
  localparam int DivLat = 33;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = 33;
`endif
  localparam int NumVec = 10;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        annul;
  logic        stallreq, busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[NumVec];
  vec_t sb[$];
  logic [31:0] last_hi, last_lo;

  muldiv_ctrl #(.DIV_ITERS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .annul_i     (annul),
    .stallreq_o  (stallreq),
    .busy_o      (busy),
    .done_o      (done),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the idle gap following done.
  task automatic run_op(input vec_t v, input string nm);
    int   lat;
    int   stalls;
    bit   got;
    vec_t e;
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    sb.push_back(v);
    #1;
    lat = 0;
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (stallreq) stalls++;
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual=no done required=done within 100 cycles", nm);
      sb.delete();
    end else begin
      e = sb.pop_front();
      check({nm, "_lat"}, 64'(lat), 64'(e.lat));
      check({nm, "_stall"}, 64'(stalls), 64'(e.lat));
      check({nm, "_stall_at_done"}, 64'(stallreq), 64'(0));
      check({nm, "_hi"}, 64'(hi), 64'(e.hi));
      check({nm, "_lo"}, 64'(lo), 64'(e.lo));
      last_hi = e.hi;
      last_lo = e.lo;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check({nm, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    vecs[0] = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1};
    vecs[1] = '{OpMult,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1};
    vecs[2] = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1};
    vecs[3] = '{OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat};
    vecs[4] = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DivLat};
    vecs[5] = '{OpDivu,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, Div0Lat};
    vecs[6] = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DivLat};
    vecs[7] = '{OpDiv,   32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'h0000_0001, Div0Lat};
    vecs[8] = '{OpDivu,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, DivLat};
    vecs[9] = '{OpMultu, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 32'h5678_0000, 1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_a = '0;
    req_b = '0;
    annul = 1'b0;
    last_hi = '0;
    last_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_stallreq", 64'(stallreq), 64'(0));

    for (int i = 0; i < NumVec; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // DIVU 50/7 annulled at iteration 10; request held so annul must win.
    req_valid = 1'b1;
    req_op = OpDivu;
    req_a = 32'd50;
    req_b = 32'd7;
    #1;
    check("annul_stall_first", 64'(stallreq), 64'(1));
    repeat (11) @(negedge clk);
    check("annul_busy_before", 64'(busy), 64'(1));
    annul = 1'b1;
    @(negedge clk);
    check("annul_busy_after", 64'(busy), 64'(0));
    check("annul_done_after", 64'(done), 64'(0));
    check("annul_hi", 64'(hi), 64'(last_hi));
    check("annul_lo", 64'(lo), 64'(last_lo));
    // Still annulled with req_valid high in IDLE: must not be accepted.
    @(negedge clk);
    check("annul_prio_busy", 64'(busy), 64'(0));
    annul = 1'b0;
    req_valid = 1'b0;
    begin
      int spurious = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done) spurious++;
      end
      check("annul_no_done", 64'(spurious), 64'(0));
    end
    run_op('{OpDivu, 32'd10, 32'd3, 32'd1, 32'd3, DivLat}, "divu10_3");

    // Synchronous reset mid-divide.
    req_valid = 1'b1;
    req_op = OpDiv;
    req_a = 32'd1000;
    req_b = 32'd9;
    repeat (6) @(negedge clk);
    check("rstmid_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_done", 64'(done), 64'(0));
    check("rstmid_hi", 64'(hi), 64'(0));
    check("rstmid_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    run_op(vecs[1], "post_rst_mult");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
